// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR keystream blocks: register width, tap
// mask, default seed, FSM state codes and the single-step LFSR function.
package lfsr_pkg;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] TAP_MASK     = 16'hB400;   // taps 15,13,12,10
  localparam logic [15:0] DEFAULT_SEED = 16'h0001;

  // Scheduler state codes, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t GEN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // One Fibonacci step: returns {next_state, out_bit}.
  // The out bit is the MSB before the shift; feedback enters at bit 0.
  function automatic logic [16:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = ^(s & TAP_MASK);
    return {s[14:0], fb, s[15]};
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// 16-bit Fibonacci LFSR with step enable and seed load. An all-zero load
// value is replaced by SEED so the register can never lock up at zero.
module lfsr_step_core
  import lfsr_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] state,
  output logic        out_bit
);

  logic [15:0] state_r;
  logic [15:0] seed_s;
  logic [16:0] step_s;

  assign step_s  = lfsr_next(state_r);
  assign out_bit = step_s[0];
  assign state   = state_r;

  // Substitute the reset seed for an all-zero load value.
  always_comb begin
    seed_s = load_val;
    if (load_val == 16'h0000) begin
      seed_s = SEED;
    end else begin
      seed_s = load_val;
    end
  end

  // LFSR register: load wins over step; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SEED;
    end else if (load) begin
      state_r <= seed_s;
    end else if (en) begin
      state_r <= step_s[16:1];
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/lfsr_keystream_sched.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters. Each grant
// clocks the LFSR eight times and returns the bits MSB-first as one byte
// tagged with the owning requester index.
module lfsr_keystream_sched
  import lfsr_pkg::*;
#(
  parameter int          NREQ = 4,
  parameter logic [15:0] SEED = DEFAULT_SEED,
  localparam int         IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [15:0]     seed_i,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            ks_valid,
  output logic [7:0]      ks_data,
  output logic [IDW-1:0]  ks_id,
  output logic [15:0]     lfsr_state
);

  state_t         state_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] winner_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     byte_r;

  logic           lfsr_en_s;
  logic           lfsr_load_s;
  logic           lfsr_out_s;
  logic           win_found_s;
  logic [IDW-1:0] win_idx_s;
  int             cand_s;

  assign busy        = (state_r != IDLE);
  assign lfsr_en_s   = (state_r == GEN);
  assign lfsr_load_s = (state_r == IDLE) && seed_load;

  lfsr_step_core #(.SEED(SEED)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (lfsr_en_s),
    .load     (lfsr_load_s),
    .load_val (seed_i),
    .state    (lfsr_state),
    .out_bit  (lfsr_out_s)
  );

  // Round-robin search: first active request above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDW{1'b0}};
    cand_s      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = (int'(rr_ptr_r) + i) % NREQ;
      if (!win_found_s && req[cand_s[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Scheduler FSM with registered grant / keystream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= IDW'(NREQ - 1);
      winner_r  <= {IDW{1'b0}};
      bit_cnt_r <= 3'd0;
      byte_r    <= 8'h00;
      grant     <= {NREQ{1'b0}};
      ks_valid  <= 1'b0;
      ks_data   <= 8'h00;
      ks_id     <= {IDW{1'b0}};
    end else begin
      grant    <= {NREQ{1'b0}};
      ks_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (seed_load) begin
            state_r <= IDLE;
          end else if (win_found_s) begin
            winner_r  <= win_idx_s;
            rr_ptr_r  <= win_idx_s;
            bit_cnt_r <= 3'd0;
            grant     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
            state_r   <= GEN;
          end else begin
            state_r <= IDLE;
          end
        end
        GEN: begin
          byte_r    <= {byte_r[6:0], lfsr_out_s};
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            ks_valid <= 1'b1;
            ks_data  <= {byte_r[6:0], lfsr_out_s};
            ks_id    <= winner_r;
            state_r  <= DONE;
          end else begin
            state_r <= GEN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lfsr_keystream_sched.md
# lfsr_keystream_sched

Round-robin scheduler that shares one 16-bit Fibonacci LFSR keystream generator among NREQ requesters. Each granted request clocks the LFSR exactly 8 times and returns the 8 collected output bits as one keystream byte tagged with the requester index. The block also handles seed loading and prevents the LFSR from entering the all-zero lock-up state. It sits between the chaotic/LFSR core and the byte-oriented consumers (scramblers, test-pattern sources).

## Interface
- NREQ, 4, number of requesters (2..8).
- SEED, 16'h0001, reset seed; also substituted for any all-zero seed load.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  level request per requester; held until that requester's byte is delivered.
- seed_load  in  1  load seed_i into the LFSR (honoured only in IDLE).
- seed_i  in  16  new seed value.
- grant  out  NREQ  one-hot, one-cycle pulse in the first GEN cycle.
- busy  out  1  high whenever state != IDLE.
- ks_valid  out  1  one-cycle pulse; ks_data and ks_id are valid.
- ks_data  out  8  keystream byte.
- ks_id  out  $clog2(NREQ)  index of the requester that owns ks_data.
- lfsr_state  out  16  current LFSR register, for debug and verification.

## Operation
- LFSR step: fb = s[15]^s[13]^s[12]^s[10]; out bit = s[15] before the shift; s <= {s[14:0], fb}. The LFSR only steps in GEN.
- Byte assembly: MSB first. The first bit produced goes to ks_data[7], the eighth to ks_data[0].
- FSM states: IDLE, GEN, DONE.
- IDLE, seed_load=1: LFSR <= (seed_i==0 ? SEED : seed_i). Stay in IDLE. Seed load has priority over req in the same cycle; pending requests are arbitrated next cycle.
- IDLE, req!=0 and no seed_load: choose a winner round-robin, searching upward from rr_ptr+1 with wrap. Latch the winner index, set rr_ptr <= winner, clear bit_cnt, go to GEN.
- GEN: step the LFSR and shift the out bit into the byte register each cycle. bit_cnt counts 0..7. After the step at bit_cnt=7, go to DONE.
- DONE: ks_valid=1 with ks_data and ks_id. Go to IDLE.
- seed_load outside IDLE is ignored, with no queueing. Callers must wait for busy=0.
- Once granted, req is not sampled again. Dropping req mid-GEN does not abort the byte.
- A req that drops before it is granted is never served.

## Timing
- Reset values: state=IDLE, LFSR=SEED, rr_ptr=NREQ-1 (req[0] has first priority), grant=0, busy=0, ks_valid=0, ks_data=0, ks_id=0, bit_cnt=0.
- Request sampled in IDLE at edge t:
  - grant and busy rise in cycle t+1.
  - GEN occupies cycles t+1..t+8.
  - ks_valid is high in cycle t+9.
  - IDLE is re-entered at t+10.
- Throughput: one byte per 10 cycles with continuous requests.
- ks_data and ks_id hold their values after ks_valid until the next DONE.
- Reset asserted mid-GEN: the byte is discarded, no ks_valid is issued, and the LFSR returns to SEED.
- All outputs are registered except busy, which is decoded from the state register.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_W=16, the tap mask 16'hB400 (bits 15,13,12,10), and DEFAULT_SEED=16'h0001.
  - The state enum {IDLE, GEN, DONE}.
  - An lfsr_next() function returning {next_state, out_bit}.
- One sub-module, lfsr_step_core: a 16-bit LFSR with en, load and load_val inputs, plus zero-seed substitution. It is reused by later chaotic-LFSR blocks.
- The round-robin arbiter stays inline, since it is a single priority search.

## Test plan
- Reset, then pulse req[0] once -> grant=0001 one cycle later, ks_valid 9 cycles after the request edge, ks_data=8'h00, ks_id=0, lfsr_state=16'h0100.
- Second req[0] after the first byte -> ks_data=8'h01, lfsr_state=16'h002D.
- Hold req=4'b1111 continuously -> grants in order 0,1,2,3,0; ks_id follows; exactly 10 cycles between ks_valid pulses.
- In IDLE, seed_load=1 with seed_i=16'h0000 -> lfsr_state=16'h0001. With seed_i=16'hACE1 -> lfsr_state=16'hACE1. seed_load during GEN -> lfsr_state evolves unaffected.
- seed_load and req[2] asserted in the same IDLE cycle -> seed loaded first, grant[2] one cycle later, and the byte matches the lfsr_next() model from the new seed.
- Assert rst in the 4th GEN cycle -> no ks_valid, lfsr_state=16'h0001, busy=0; a following req[1] yields ks_data=8'h00.
